// File: rtl/if_prefetch_unit_pkg.sv
// Shared constants and the FIFO entry layout for the instruction-fetch front end.
package if_prefetch_unit_pkg;

   localparam int          XLEN             = 32;
   localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
   localparam logic [31:0] FETCH_STRIDE     = 32'h0000_0004;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] instr;
   } fetch_entry_t;

   function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
      return addr & ~32'h0000_0003;
   endfunction

endpackage

// File: rtl/if_prefetch_unit_fifo.sv
// Synchronous prefetch FIFO holding {pc, instr} pairs; flush empties it in one cycle.
module if_prefetch_unit_fifo
   import if_prefetch_unit_pkg::*;
#(
   parameter int DEPTH = 4,
   localparam int PW = $clog2(DEPTH),
   localparam int CW = PW + 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              push_i,
   input  logic              pop_i,
   input  logic              flush_i,
   input  logic [2*XLEN-1:0] wdata_i,
   output logic [2*XLEN-1:0] rdata_o,
   output logic              empty_o,
   output logic [CW-1:0]     count_o
);

   fetch_entry_t      mem_q [DEPTH];
   logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]     count_q, count_d;

   // Pointer and occupancy next-state; pointers wrap naturally since DEPTH is a power of 2.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush_i) begin
         wr_ptr_d = {PW{1'b0}};
         rd_ptr_d = {PW{1'b0}};
         count_d  = {CW{1'b0}};
      end else begin
         if (push_i) wr_ptr_d = wr_ptr_q + PW'(1);
         else        wr_ptr_d = wr_ptr_q;
         if (pop_i)  rd_ptr_d = rd_ptr_q + PW'(1);
         else        rd_ptr_d = rd_ptr_q;
         case ({push_i, pop_i})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   // Pointer and occupancy registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= {PW{1'b0}};
         rd_ptr_q <= {PW{1'b0}};
         count_q  <= {CW{1'b0}};
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Entry storage; contents are only observable through a valid head, so no reset.
   always_ff @(posedge clk) begin
      if (push_i && !flush_i) mem_q[wr_ptr_q] <= fetch_entry_t'(wdata_i);
   end

   assign rdata_o = mem_q[rd_ptr_q];
   assign empty_o = (count_q == {CW{1'b0}});
   assign count_o = count_q;

endmodule

// File: rtl/if_prefetch_unit.sv
// Instruction-fetch front end: fetch PC, single-outstanding imem request, redirect/discard
// handling, and the prefetch FIFO whose head feeds the IF/ID register.
module if_prefetch_unit
   import if_prefetch_unit_pkg::*;
#(
   parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
   parameter int          DEPTH    = 4
) (
   input  logic        clk,
   input  logic        reset,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   input  logic        id_ready,
   input  logic        redirect,
   input  logic [31:0] redirect_addr,
   output logic        if_valid,
   output logic [31:0] Instruction_if,
   output logic [31:0] PC
);

   localparam int            CW      = $clog2(DEPTH) + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   logic          req_q, req_d;
   logic          discard_q, discard_d;
   logic [31:0]   fpc_q, fpc_d;
   logic [31:0]   addr_q, addr_d;
   logic          xfer_s, hold_s, push_s, pop_s, empty_s;
   logic [CW-1:0] count_s, count_next_s;
   logic [63:0]   head_s;
   fetch_entry_t  head_e;

   assign head_e = fetch_entry_t'(head_s);

   // Issue/redirect decisions. addr_q freezes while a request waits for its ack, so a
   // redirect during that time only moves fpc and marks the in-flight word for discard.
   always_comb begin
      xfer_s       = req_q & imem_ack;
      hold_s       = req_q & ~imem_ack;
      push_s       = xfer_s & ~discard_q & ~redirect;
      pop_s        = ~empty_s & id_ready & ~redirect;
      count_next_s = count_s;
      fpc_d        = fpc_q;
      discard_d    = discard_q;
      req_d        = 1'b0;
      addr_d       = addr_q;

      if (redirect) begin
         count_next_s = {CW{1'b0}};
      end else begin
         case ({push_s, pop_s})
            2'b10:   count_next_s = count_s + CW'(1);
            2'b01:   count_next_s = count_s - CW'(1);
            default: count_next_s = count_s;
         endcase
      end

      if (redirect)    fpc_d = word_align(redirect_addr);
      else if (push_s) fpc_d = fpc_q + FETCH_STRIDE;
      else             fpc_d = fpc_q;

      if (redirect)    discard_d = hold_s;
      else if (xfer_s) discard_d = 1'b0;
      else             discard_d = discard_q;

      if (hold_s)        req_d = 1'b1;
      else if (redirect) req_d = 1'b0;
      else               req_d = (count_next_s < DEPTH_C);

      if (hold_s) addr_d = addr_q;
      else        addr_d = fpc_d;
   end

   // Fetch state registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         req_q     <= 1'b0;
         discard_q <= 1'b0;
         fpc_q     <= RESET_PC;
         addr_q    <= RESET_PC;
      end else begin
         req_q     <= req_d;
         discard_q <= discard_d;
         fpc_q     <= fpc_d;
         addr_q    <= addr_d;
      end
   end

   if_prefetch_unit_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .rst_n   (reset),
      .push_i  (push_s),
      .pop_i   (pop_s),
      .flush_i (redirect),
      .wdata_i ({addr_q, imem_rdata}),
      .rdata_o (head_s),
      .empty_o (empty_s),
      .count_o (count_s)
   );

   assign imem_req       = req_q;
   assign imem_addr      = addr_q;
   assign if_valid       = ~empty_s;
   assign Instruction_if = empty_s ? NOP_INSTR : head_e.instr;
   assign PC             = empty_s ? 32'h0000_0000 : head_e.pc;

endmodule

// File: tb/tb_if_prefetch_unit.sv
// Randomized bench for if_prefetch_unit: the expected instruction stream is derived from
// program order (PC += 4, redirect restarts it) and checked as IF/ID consumes instructions.
module tb_if_prefetch_unit;

   localparam logic [31:0] NOP      = 32'h0000_0013;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic        clk;
   logic        reset;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        id_ready;
   logic        redirect;
   logic [31:0] redirect_addr;
   logic        if_valid;
   logic [31:0] Instruction_if;
   logic [31:0] PC;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
   } exp_t;

   exp_t        exp_q[$];
   exp_t        mon_e;
   logic [31:0] model_pc;
   int          checks     = 0;
   int          errors     = 0;
   int          ack_pct    = 100;
   int          n_consumed = 0;
   int          c0;
   logic        held;
   logic [31:0] held_addr;

   if_prefetch_unit #(.RESET_PC(RESET_PC), .DEPTH(4)) dut (
      .clk            (clk),
      .reset          (reset),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_ack       (imem_ack),
      .imem_rdata     (imem_rdata),
      .id_ready       (id_ready),
      .redirect       (redirect),
      .redirect_addr  (redirect_addr),
      .if_valid       (if_valid),
      .Instruction_if (Instruction_if),
      .PC             (PC)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], ~a[31:16]} ^ 32'hC3A5_9E17;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   function automatic void sb_restart(input logic [31:0] pc);
      exp_q.delete();
      model_pc = pc & 32'hFFFF_FFFC;
   endfunction

   function automatic void sb_topup();
      exp_t e;
      while (exp_q.size() < 16) begin
         e.pc    = model_pc;
         e.instr = mem_word(model_pc);
         exp_q.push_back(e);
         model_pc = model_pc + 32'd4;
      end
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
      sb_topup();
   endtask

   task automatic do_redirect(input logic [31:0] target);
      redirect      = 1'b1;
      redirect_addr = target;
      sb_restart(target);
      sb_topup();
      step();
      redirect = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      exp_q.delete();
      step();
      step();
      reset = 1'b1;
      sb_restart(RESET_PC);
      sb_topup();
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_if_valid"}, 32'(if_valid), 32'd0);
      check({tag, "_instr"}, Instruction_if, NOP);
      check({tag, "_pc"}, PC, 32'h0000_0000);
      check({tag, "_req"}, 32'(imem_req), 32'd0);
      check({tag, "_addr"}, imem_addr, RESET_PC);
   endtask

   // Instruction memory: acks a pending request with probability ack_pct.
   initial begin
      imem_ack   = 1'b0;
      imem_rdata = 32'h0000_0000;
   end
   always @(posedge clk) begin
      #2;
      if (imem_req && (int'($urandom_range(99)) < ack_pct)) begin
         imem_ack   = 1'b1;
         imem_rdata = mem_word(imem_addr);
      end else begin
         imem_ack   = 1'b0;
         imem_rdata = $urandom;
      end
   end

   // Scoreboard monitor: compares every instruction IF/ID accepts against the expected stream.
   always @(negedge clk) begin
      if (reset) begin
         if (!if_valid) begin
            check("empty_instr", Instruction_if, NOP);
            check("empty_pc", PC, 32'h0000_0000);
         end else if (id_ready && !redirect) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL sb_underflow actual_pc=%h required=expected-entry", PC);
            end else begin
               mon_e = exp_q.pop_front();
               check("pc", PC, mon_e.pc);
               check("instr", Instruction_if, mon_e.instr);
               n_consumed++;
            end
         end
      end
   end

   // Request protocol: an unacked request keeps req high with a stable, aligned address.
   always @(negedge clk) begin
      if (!reset) begin
         held = 1'b0;
      end else begin
         if (held) begin
            check("req_hold", 32'(imem_req), 32'd1);
            check("addr_hold", imem_addr, held_addr);
         end
         if (imem_req) check("addr_align", {30'b0, imem_addr[1:0]}, 32'd0);
         held      = imem_req && !imem_ack;
         held_addr = imem_addr;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset         = 1'b1;
      id_ready      = 1'b0;
      redirect      = 1'b0;
      redirect_addr = 32'h0000_0000;
      held          = 1'b0;
      held_addr     = 32'h0000_0000;
      ack_pct       = 100;
      #2 reset = 1'b0;
      #1;
      check_reset_outputs("por");
      step();
      step();
      check_reset_outputs("por_held");

      // Release, then FIFO fills with id_ready low and the request stops.
      reset = 1'b1;
      sb_restart(RESET_PC);
      sb_topup();
      step();
      check("rel_req_edge1", 32'(imem_req), 32'd1);
      check("rel_addr_edge1", imem_addr, 32'h0000_0000);
      repeat (9) step();
      check("full_req_drop", 32'(imem_req), 32'd0);
      check("full_next_addr", imem_addr, 32'h0000_0010);
      check("full_valid", 32'(if_valid), 32'd1);
      check("full_head_pc", PC, 32'h0000_0000);
      id_ready = 1'b1;
      step();
      check("resume_req", 32'(imem_req), 32'd1);
      check("resume_addr", imem_addr, 32'h0000_0010);

      // Sustained throughput with ack every cycle.
      c0 = n_consumed;
      repeat (20) step();
      check("rate_20cyc", 32'(n_consumed - c0), 32'd20);

      // Redirect while 0x0C is outstanding; its late ack must be dropped.
      do_reset();
      id_ready = 1'b1;
      ack_pct  = 100;
      for (int i = 0; i < 20 && !(imem_req && imem_addr == 32'h0000_000C); i++) step();
      check("disc_setup_addr", imem_addr, 32'h0000_000C);
      ack_pct = 0;
      do_redirect(32'h0000_0103);
      check("disc_req_held", 32'(imem_req), 32'd1);
      check("disc_addr_held", imem_addr, 32'h0000_000C);
      check("disc_flushed", 32'(if_valid), 32'd0);
      step();
      step();
      ack_pct = 100;
      step();
      ack_pct = 0;
      check("disc_new_req", 32'(imem_req), 32'd1);
      check("disc_new_addr", imem_addr, 32'h0000_0100);
      check("disc_no_valid", 32'(if_valid), 32'd0);
      step();
      check("disc_still_empty", 32'(if_valid), 32'd0);
      ack_pct = 100;
      step();
      check("disc_target_valid", 32'(if_valid), 32'd1);
      check("disc_target_pc", PC, 32'h0000_0100);

      // Redirect, ack and pop all in one cycle with two entries buffered.
      do_reset();
      id_ready = 1'b0;
      ack_pct  = 100;
      step();
      step();
      step();
      check("rap_two_valid", 32'(if_valid), 32'd1);
      check("rap_next_addr", imem_addr, 32'h0000_0008);
      id_ready = 1'b1;
      do_redirect(32'h0000_0200);
      check("rap_empty", 32'(if_valid), 32'd0);
      check("rap_req_low", 32'(imem_req), 32'd0);
      check("rap_addr", imem_addr, 32'h0000_0200);
      step();
      check("rap_issue_req", 32'(imem_req), 32'd1);
      check("rap_issue_addr", imem_addr, 32'h0000_0200);

      // Fetch address wrap at the top of the address space.
      do_redirect(32'hFFFF_FFFE);
      check("wrap_aligned", imem_addr, 32'hFFFF_FFFC);
      step();
      check("wrap_req", 32'(imem_req), 32'd1);
      step();
      check("wrap_addr", imem_addr, 32'h0000_0000);
      repeat (4) step();

      // Randomized traffic with random stalls, memory latency and redirects.
      c0 = n_consumed;
      for (int i = 0; i < 3000; i++) begin
         id_ready = ($urandom_range(9) < 7);
         if ((i % 500) == 0) ack_pct = 30 + int'($urandom_range(60));
         if ($urandom_range(99) < 4) begin
            if ($urandom_range(3) == 0) do_redirect(32'hFFFF_FFF0 + 32'($urandom_range(15)));
            else                        do_redirect($urandom);
         end else begin
            step();
         end
      end
      check("rand_progress", 32'(n_consumed - c0 >= 300), 32'd1);

      // Asynchronous reset mid-cycle with traffic in flight.
      ack_pct  = 100;
      id_ready = 1'b1;
      repeat (5) step();
      #2 reset = 1'b0;
      exp_q.delete();
      #1;
      check_reset_outputs("async");
      @(posedge clk);
      #1;
      reset = 1'b1;
      sb_restart(RESET_PC);
      sb_topup();
      step();
      check("async_rel_req", 32'(imem_req), 32'd1);
      check("async_rel_addr", imem_addr, 32'h0000_0000);
      repeat (8) step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
